// File: rtl/aes_128_pkg.sv
// rtl/aes_128_pkg.sv - shared definitions for the AES-128 key expansion block
//
// Purpose : S-box table, Rcon start value, xtime helper, FSM state type and
//           round-key RAM word geometry shared by the key expansion RTL.
// Ports   : none (package).
// Config  : AES_KEYEXP_ZEROIZE_EN is consumed by aes_128_key_expand, not here.

package aes_128_pkg;

  localparam int RK_WORD_W   = 64;
  localparam int RK_WORD_CNT = 22;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [3:0] LAST_ROUND = 4'd10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_LO = 3'd1,
    WR_HI = 3'd2,
    SUB   = 3'd3,
    MIX   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_128_sbox_word.sv
// rtl/aes_128_sbox_word.sv - four parallel registered S-box byte lookups
//
// Purpose : SubWord on a 32-bit word with one cycle of latency. The output
//           register has no reset so each lane can map onto a ROM/BRAM.
// Ports   : i_clk   - clock
//           i_en    - load the lookup result of i_word
//           i_clr   - clear the output register (takes priority over i_en)
//           i_word  - input word, byte lane n at bits [8n+7:8n]
//           o_word  - registered substituted word, same lane order

module aes_128_sbox_word
  import aes_128_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  logic [31:0] r_word;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_word <= '0;
    end else if (i_en) begin
      for (int i = 0; i < 4; i++) begin
        r_word[8*i +: 8] <= SBOX[i_word[8*i +: 8]];
      end
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/aes_128_key_expand.sv
// rtl/aes_128_key_expand.sv - AES-128 key expansion writing round keys to a key RAM
//
// Purpose : Expands a 128-bit cipher key into round keys 0..10 and writes each
//           as two 64-bit words (bytes 0..7 then 8..15) at BASE_ADDR+2k and
//           BASE_ADDR+2k+1. One round takes four cycles: WR_LO, WR_HI, SUB, MIX.
// Ports   : clk          - clock, rising edge
//           kill_n       - synchronous active-low reset
//           start        - one-cycle request, honoured only in IDLE
//           key_in       - cipher key, byte 0 at bits [7:0]
//           busy         - expansion in progress
//           done         - one-cycle pulse after the last word is written
//           en_wr        - key-RAM write enable
//           addr         - key-RAM word address
//           key_round_wr - key-RAM write data
// Config  : AES_KEYEXP_ZEROIZE_EN - clear working key and S-box register in DONE
//           and force key_round_wr to zero whenever en_wr is low.

module aes_128_key_expand
  import aes_128_pkg::*;
#(
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 kill_n,
  input  logic                 start,
  input  logic [127:0]         key_in,
  output logic                 busy,
  output logic                 done,
  output logic                 en_wr,
  output logic [4:0]           addr,
  output logic [RK_WORD_W-1:0] key_round_wr
);

  localparam logic [4:0] BASE = 5'(BASE_ADDR);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [127:0] r_key;
  logic [3:0]   r_round;
  logic [7:0]   r_rcon;

  logic         w_start_ok;
  logic         w_hi;
  logic [31:0]  w_sbox_in;
  logic [31:0]  w_sbox_out;
  logic         w_sbox_clr;
  logic [31:0]  w_t;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [63:0]  w_sel;
  logic [4:0]   w_addr;

  assign w_start_ok = (r_state == IDLE) && start;

  // State register
  always_ff @(posedge clk) begin
    if (!kill_n) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = WR_LO;
      WR_LO:   w_state_nxt = WR_HI;
      WR_HI:   w_state_nxt = (r_round < LAST_ROUND) ? SUB : DONE;
      SUB:     w_state_nxt = MIX;
      MIX:     w_state_nxt = WR_LO;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    en_wr = 1'b0;
    w_hi  = 1'b0;
    unique case (r_state)
      WR_LO:   begin busy = 1'b1; en_wr = 1'b1; end
      WR_HI:   begin busy = 1'b1; en_wr = 1'b1; w_hi = 1'b1; end
      SUB:     busy = 1'b1;
      MIX:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // RotWord of w[4r+3]: with byte 0 in the low lane, rotating left by one
  // byte in FIPS order is a right rotate of the packed word.
  assign w_sbox_in = {r_key[103:96], r_key[127:104]};

`ifdef AES_KEYEXP_ZEROIZE_EN
  assign w_sbox_clr = (r_state == DONE);
`else
  assign w_sbox_clr = 1'b0;
`endif

  aes_128_sbox_word u_sbox (
    .i_clk  (clk),
    .i_en   (r_state == SUB),
    .i_clr  (w_sbox_clr),
    .i_word (w_sbox_in),
    .o_word (w_sbox_out)
  );

  // Rcon lands on FIPS byte 0 of the word, which is the low lane here.
  assign w_t  = w_sbox_out ^ {24'h0, r_rcon};
  assign w_n0 = r_key[31:0]   ^ w_t;
  assign w_n1 = r_key[63:32]  ^ w_n0;
  assign w_n2 = r_key[95:64]  ^ w_n1;
  assign w_n3 = r_key[127:96] ^ w_n2;

  always_ff @(posedge clk) begin
    if (!kill_n) begin
      r_key   <= '0;
      r_round <= '0;
      r_rcon  <= RCON_INIT;
    end else if (w_start_ok) begin
      r_key   <= key_in;
      r_round <= '0;
      r_rcon  <= RCON_INIT;
    end else if (r_state == MIX) begin
      r_key   <= {w_n3, w_n2, w_n1, w_n0};
      r_round <= r_round + 4'd1;
      r_rcon  <= xtime(r_rcon);
    end
`ifdef AES_KEYEXP_ZEROIZE_EN
    else if (r_state == DONE) begin
      r_key <= '0;
    end
`endif
  end

  assign w_sel  = w_hi ? r_key[127:64] : r_key[63:0];
  assign w_addr = BASE + {r_round, 1'b0} + {4'b0, w_hi};
  assign addr   = en_wr ? w_addr : 5'd0;

`ifdef AES_KEYEXP_ZEROIZE_EN
  assign key_round_wr = en_wr ? w_sel : '0;
`else
  assign key_round_wr = w_sel;
`endif

endmodule
